// File: rtl/gamma_coder_seq_pkg.sv
// Shared types and constants for the gamma coder sequencer and key checkers.
package gamma_pkg;

  localparam int NK_W = 8;
  localparam int MD_W = 9;

  // Noise keys that carry no entropy and are always rejected.
  localparam logic [NK_W-1:0] KEY_ZERO = 8'h00;
  localparam logic [NK_W-1:0] KEY_ONES = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WARM  = 3'd1,
    LOAD  = 3'd2,
    CHECK = 3'd3,
    MIX   = 3'd4,
    CAP   = 3'd5,
    OUT   = 3'd6
  } state_t;

endpackage

// File: rtl/gamma_key_screen.sv
// Combinational weak-key detector: all-zero, all-one, or repeat of the
// last accepted key.
module gamma_key_screen
  import gamma_pkg::*;
(
  input  logic [NK_W-1:0] nk,
  input  logic [NK_W-1:0] last_key,
  input  logic            last_key_vld,
  output logic            key_bad
);

  // Flag a key that must not be used for mixing.
  always_comb begin
    key_bad = (nk == KEY_ZERO) || (nk == KEY_ONES) ||
              (last_key_vld && (nk == last_key));
  end

endmodule

// File: rtl/gamma_coder_seq.sv
// Sequencer driving gen_gamma_coder: warm-up, key load, key screening with
// retries, mix, and result hand-off over valid/ready.
module gamma_coder_seq
  import gamma_pkg::*;
#(
  parameter int WARMUP    = 16,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic            en,
  output logic            set0,
  output logic            set1,
  output logic [7:0]      id,
  input  logic [NK_W-1:0] nk,
  input  logic [MD_W-1:0] md,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MD_W-1:0] out_md,
  output logic [NK_W-1:0] out_nk,
  output logic            out_err,
  output logic            busy
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WARMUP - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        retry_q, retry_d;
  logic              err_q, err_d;
  logic [NK_W-1:0]   last_key_q, last_key_d;
  logic              last_key_vld_q, last_key_vld_d;
  logic [7:0]        id_q, id_d;
  logic              en_q, en_d;
  logic              set0_q, set0_d;
  logic              set1_q, set1_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [MD_W-1:0]   out_md_q, out_md_d;
  logic [NK_W-1:0]   out_nk_q, out_nk_d;
  logic              out_err_q, out_err_d;
  logic              key_bad;

  gamma_key_screen u_key_screen (
    .nk           (nk),
    .last_key     (last_key_q),
    .last_key_vld (last_key_vld_q),
    .key_bad      (key_bad)
  );

  // Next-state, datapath and registered-output decode.
  // Control outputs are decoded from the next state so they are registered
  // yet aligned with the state they belong to.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    retry_d        = retry_q;
    err_d          = err_q;
    last_key_d     = last_key_q;
    last_key_vld_d = last_key_vld_q;
    id_d           = id_q;
    out_md_d       = out_md_q;
    out_nk_d       = out_nk_q;
    out_err_d      = out_err_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          id_d    = in_data;
          cnt_d   = '0;
          retry_d = '0;
          state_d = WARM;
        end
      end
      WARM: begin
        if (cnt_q == CNT_LAST) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (key_bad) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            cnt_d   = '0;
            state_d = WARM;
          end else begin
            err_d   = 1'b1;
            state_d = MIX;
          end
        end else begin
          err_d   = 1'b0;
          state_d = MIX;
        end
      end
      MIX: begin
        state_d = CAP;
      end
      CAP: begin
        out_md_d  = md;
        out_nk_d  = nk;
        out_err_d = err_q;
        if (!err_q) begin
          last_key_d     = nk;
          last_key_vld_d = 1'b1;
        end
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    en_d        = (state_d == WARM) || (state_d == LOAD);
    set0_d      = (state_d == LOAD);
    set1_d      = (state_d == MIX);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == OUT);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      retry_q        <= '0;
      err_q          <= 1'b0;
      last_key_q     <= '0;
      last_key_vld_q <= 1'b0;
      id_q           <= '0;
      en_q           <= 1'b0;
      set0_q         <= 1'b0;
      set1_q         <= 1'b0;
      in_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_md_q       <= '0;
      out_nk_q       <= '0;
      out_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      err_q          <= err_d;
      last_key_q     <= last_key_d;
      last_key_vld_q <= last_key_vld_d;
      id_q           <= id_d;
      en_q           <= en_d;
      set0_q         <= set0_d;
      set1_q         <= set1_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      out_valid_q    <= out_valid_d;
      out_md_q       <= out_md_d;
      out_nk_q       <= out_nk_d;
      out_err_q      <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign en        = en_q;
  assign set0      = set0_q;
  assign set1      = set1_q;
  assign id        = id_q;
  assign out_valid = out_valid_q;
  assign out_md    = out_md_q;
  assign out_nk    = out_nk_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gamma_coder_seq.sv
// Directed bench for gamma_coder_seq with a behavioural coder model.
module tb_gamma_coder_seq;

  localparam int WARMUP    = 4;
  localparam int MAX_RETRY = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       en;
  logic       set0;
  logic       set1;
  logic [7:0] id;
  logic [7:0] nk_m = 8'h00;
  logic [8:0] md_m = 9'h000;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_md;
  logic [7:0] out_nk;
  logic       out_err;
  logic       busy;

  always #5 clk = ~clk;

  gamma_coder_seq #(
    .WARMUP    (WARMUP),
    .MAX_RETRY (MAX_RETRY),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .en        (en),
    .set0      (set0),
    .set1      (set1),
    .id        (id),
    .nk        (nk_m),
    .md        (md_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_md    (out_md),
    .out_nk    (out_nk),
    .out_err   (out_err),
    .busy      (busy)
  );

  // Coder model: key sequence comes from a queue, mix is nk + id.
  logic [7:0] key_q[$];
  always @(posedge clk) begin
    if (set0 && key_q.size() > 0) nk_m <= key_q.pop_front();
    if (set1) md_m <= {1'b0, nk_m} + {1'b0, id};
  end

  // Pulse counters and protocol-violation flag.
  int   n_en = 0, n_set0 = 0, n_set1 = 0, cyc = 0, t_set0 = 0, t_set1 = 0;
  logic viol = 1'b0;
  always @(posedge clk) begin
    cyc++;
    if (en) n_en++;
    if (set0) begin n_set0++; t_set0 = cyc; end
    if (set1) begin n_set1++; t_set1 = cyc; end
    if (set0 && set1) viol = 1'b1;
    if (en && (set1 || out_valid || !busy)) viol = 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one byte and wait (bounded) for out_valid; checks the result.
  task automatic txn(input string name, input logic [7:0] d, input int exp_lat,
                     input int exp_set0, input logic [8:0] exp_md,
                     input logic [7:0] exp_nk, input logic exp_err);
    int e0, s0, s1, lat;
    e0 = n_en; s0 = n_set0; s1 = n_set1;
    check({name, "_in_ready_pre"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_lat"},  lat, exp_lat);
    check({name, "_set0"}, n_set0 - s0, exp_set0);
    check({name, "_set1"}, n_set1 - s1, 1);
    check({name, "_en"},   n_en - e0, exp_set0 * (WARMUP + 1));
    check({name, "_md"},   out_md, exp_md);
    check({name, "_nk"},   out_nk, exp_nk);
    check({name, "_err"},  out_err, exp_err);
    check({name, "_id"},   id, d);
  endtask

  task automatic pop(input string name);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_pop_valid"}, out_valid, 0);
    check({name, "_pop_ready"}, in_ready, 1);
    check({name, "_pop_busy"},  busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_en", en, 0);
    check("rst_set0", set0, 0);
    check("rst_set1", set1, 0);
    check("rst_id", id, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_md", out_md, 0);
    check("rst_out_nk", out_nk, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready with nothing pending does nothing
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready_valid", out_valid, 0);
    check("idle_ready_busy", busy, 0);

    // Good key on first try
    key_q.push_back(8'h5A);
    txn("good", 8'h33, WARMUP + 4, 1, 9'h08D, 8'h5A, 1'b0);
    check("good_gap", t_set1 - t_set0, 2);
    pop("good");

    // One rejected (zero) key, then a good one
    key_q.push_back(8'h00);
    key_q.push_back(8'hC3);
    txn("retry", 8'h10, 2 * WARMUP + 6, 2, 9'h0D3, 8'hC3, 1'b0);
    pop("retry");

    // Stuck all-ones key exhausts the retries
    repeat (MAX_RETRY + 1) key_q.push_back(8'hFF);
    txn("exhaust", 8'h01, WARMUP + 4 + MAX_RETRY * (WARMUP + 2), MAX_RETRY + 1,
        9'h100, 8'hFF, 1'b1);
    pop("exhaust");

    // History must still be C3: C3 rejected once, 21 accepted
    key_q.push_back(8'hC3);
    key_q.push_back(8'h21);
    txn("hist", 8'h05, 2 * WARMUP + 6, 2, 9'h026, 8'h21, 1'b0);
    pop("hist");

    // Repeat of 21 rejected, 44 accepted
    key_q.push_back(8'h21);
    key_q.push_back(8'h44);
    txn("repeat", 8'h06, 2 * WARMUP + 6, 2, 9'h04A, 8'h44, 1'b0);
    pop("repeat");

    // Backpressure: result held, new byte ignored
    key_q.push_back(8'h77);
    txn("bp", 8'h02, WARMUP + 4, 1, 9'h079, 8'h77, 1'b0);
    begin
      int s0;
      s0 = n_set0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h99;
        check("bp_valid", out_valid, 1);
        check("bp_md", out_md, 9'h079);
        check("bp_nk", out_nk, 8'h77);
        check("bp_in_ready", in_ready, 0);
      end
      pop("bp");
      check("bp_id_kept", id, 8'h02);
      @(posedge clk);
      #1;
      check("bp_no_start", busy, 0);
      check("bp_no_set0", n_set0 - s0, 0);
    end

    // Asynchronous reset in the middle of WARM
    key_q.delete();
    key_q.push_back(8'h11);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ar_en_before", en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_en", en, 0);
    check("ar_set0", set0, 0);
    check("ar_set1", set1, 0);
    check("ar_busy", busy, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_id", id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_in_ready_post", in_ready, 1);

    // History cleared: 77 is accepted again
    key_q.delete();
    key_q.push_back(8'h77);
    txn("post", 8'h08, WARMUP + 4, 1, 9'h07F, 8'h77, 1'b0);
    pop("post");

    check("protocol_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
